// File: rtl/reservation_station_mc_pkg.sv
// Shared types for the multi-CDB reservation station: CDB, rename and issue
// packets plus the per-entry storage record. Ordering lives in the age matrix.
package reservation_station_mc_pkg;

   localparam int RS_DEPTH    = 8;
   localparam int RS_IDX_LEN  = $clog2(RS_DEPTH);
   localparam int RS_NUM_CDB  = 2;
   localparam int ROB_TAG_LEN = 5;
   localparam int XLEN        = 32;

   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [XLEN-1:0]        value;
   } CDB_DATA;

   typedef struct packed {
      logic [ROB_TAG_LEN-1:0] rob_tag_val;
      logic                   rob_tag_ready;
   } MAPTABLE_PACKET;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [XLEN-1:0] rs1_value;
      logic [XLEN-1:0] rs2_value;
      logic [4:0]      dest_reg_idx;
   } ID_EX_PACKET;

   // rs_idx is sized for the default depth; wider stations need a wider RS_DEPTH here.
   typedef struct packed {
      logic [RS_IDX_LEN-1:0]  rs_idx;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      ID_EX_PACKET            inst;
   } INSTR_READY_ENTRY;

   typedef struct packed {
      logic                   valid;
      logic                   rs1_ready;
      logic                   rs2_ready;
      logic [ROB_TAG_LEN-1:0] rs1_tag;
      logic [ROB_TAG_LEN-1:0] rs2_tag;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      ID_EX_PACKET            inst;
   } RS_ENTRY;

endpackage

// File: rtl/reservation_station_mc_age_matrix.sv
// Wrap-free age matrix: age_q[i][j]=1 means entry i is older than entry j.
// Picks the ready entry that no other ready entry is older than.
module rs_age_matrix #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alloc_en,
   input  logic [$clog2(DEPTH)-1:0] alloc_idx,
   input  logic [DEPTH-1:0]         valid_mask,
   input  logic [DEPTH-1:0]         ready_mask,
   output logic [DEPTH-1:0]         oldest_onehot,
   output logic                     any_ready
);

   logic [DEPTH-1:0] age_q [DEPTH];
   logic [DEPTH-1:0] age_d [DEPTH];

   // A new entry is younger than every survivor; stale bits of freed slots are masked by ready_mask.
   always_comb begin
      age_d = age_q;
      if (alloc_en) begin
         for (int j = 0; j < DEPTH; j++) begin
            age_d[alloc_idx][j] = 1'b0;
            age_d[j][alloc_idx] = valid_mask[j];
         end
      end
   end

   always_comb begin
      oldest_onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         oldest_onehot[i] = ready_mask[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (ready_mask[j] && age_q[j][i]) oldest_onehot[i] = 1'b0;
         end
      end
   end

   assign any_ready = |ready_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/reservation_station_mc.sv
// Reservation station for one execution unit: snoops NUM_CDB result buses for
// operand wakeup and issues the oldest ready entry chosen by an age matrix.
module reservation_station_mc
   import reservation_station_mc_pkg::*;
#(
   parameter int DEPTH       = RS_DEPTH,
   parameter int NUM_CDB     = RS_NUM_CDB,
   parameter bit NO_WAIT_RS2 = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  CDB_DATA                      cdb [NUM_CDB],
   input  ID_EX_PACKET                  id_packet_out,
   input  MAPTABLE_PACKET               maptable_packet_rs1,
   input  MAPTABLE_PACKET               maptable_packet_rs2,
   input  logic [ROB_TAG_LEN-1:0]       alloc_slot,
   input  logic                         alloc_enable,
   input  logic                         issue_stall,
   output logic                         rs_full,
   output logic [$clog2(DEPTH+1)-1:0]   rs_count,
   output logic                         issue_valid,
   output INSTR_READY_ENTRY             ready_inst_entry
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   RS_ENTRY          entries_q [DEPTH];
   RS_ENTRY          entries_d [DEPTH];
   RS_ENTRY          new_entry;
   logic [CW-1:0]    count_q, count_d;
   logic [XLEN:0]    wake1 [DEPTH];
   logic [XLEN:0]    wake2 [DEPTH];
   logic [XLEN:0]    op1, op2;
   logic [DEPTH-1:0] valid_vec, ready_vec, oldest_onehot, age_valid_mask;
   logic [IW-1:0]    free_idx, sel_idx;
   logic             any_ready, issue_fire, alloc_fire;

   // Returns {hit, value}; the lowest-index matching port wins.
   function automatic logic [XLEN:0] cdb_match(input logic [ROB_TAG_LEN-1:0] tag,
                                               input CDB_DATA bus [NUM_CDB]);
      logic [XLEN:0] hit;
      hit = '0;
      for (int k = NUM_CDB-1; k >= 0; k--) begin
         if (bus[k].valid && bus[k].rob_tag == tag) hit = {1'b1, bus[k].value};
      end
      return hit;
   endfunction

   function automatic logic [XLEN:0] capture(input MAPTABLE_PACKET mt,
                                             input logic [XLEN-1:0] rf_value,
                                             input CDB_DATA bus [NUM_CDB]);
      logic [XLEN:0] r;
      if (mt.rob_tag_val == '0 || mt.rob_tag_ready) r = {1'b1, rf_value};
      else                                           r = cdb_match(mt.rob_tag_val, bus);
      return r;
   endfunction

   rs_age_matrix #(.DEPTH(DEPTH)) u_age (
      .clk           (clk),
      .reset         (reset),
      .alloc_en      (alloc_fire),
      .alloc_idx     (free_idx),
      .valid_mask    (age_valid_mask),
      .ready_mask    (ready_vec),
      .oldest_onehot (oldest_onehot),
      .any_ready     (any_ready)
   );

   // Issue handshake: an entry leaves at a posedge where issue_valid=1 and issue_stall=0;
   // while stalled, ready_inst_entry keeps tracking the current oldest ready entry.
   always_comb begin
      valid_vec = '0;
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = entries_q[i].valid;
         ready_vec[i] = entries_q[i].valid & entries_q[i].rs1_ready &
                        (entries_q[i].rs2_ready | NO_WAIT_RS2);
      end
      rs_full  = &valid_vec;
      free_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!valid_vec[i]) free_idx = IW'(i);
      end
      sel_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oldest_onehot[i]) sel_idx = IW'(i);
      end
      issue_valid    = any_ready & ~flush;
      issue_fire     = issue_valid & ~issue_stall;
      alloc_fire     = alloc_enable & ~rs_full & ~flush;
      age_valid_mask = valid_vec & ~(oldest_onehot & {DEPTH{issue_fire}});
      ready_inst_entry         = '0;
      ready_inst_entry.rs_idx  = RS_IDX_LEN'(sel_idx);
      ready_inst_entry.rob_tag = entries_q[sel_idx].rob_tag;
      ready_inst_entry.inst    = entries_q[sel_idx].inst;
   end

   always_comb begin
      op1 = capture(maptable_packet_rs1, id_packet_out.rs1_value, cdb);
      op2 = capture(maptable_packet_rs2, id_packet_out.rs2_value, cdb);
      new_entry                = '0;
      new_entry.valid          = 1'b1;
      new_entry.rs1_ready      = op1[XLEN];
      new_entry.rs2_ready      = op2[XLEN];
      new_entry.rs1_tag        = maptable_packet_rs1.rob_tag_val;
      new_entry.rs2_tag        = maptable_packet_rs2.rob_tag_val;
      new_entry.rob_tag        = alloc_slot;
      new_entry.inst           = id_packet_out;
      new_entry.inst.rs1_value = op1[XLEN-1:0];
      new_entry.inst.rs2_value = op2[XLEN-1:0];
      for (int i = 0; i < DEPTH; i++) begin
         wake1[i] = cdb_match(entries_q[i].rs1_tag, cdb);
         wake2[i] = cdb_match(entries_q[i].rs2_tag, cdb);
      end
   end

   always_comb begin
      entries_d = entries_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries_q[i].valid && !entries_q[i].rs1_ready && wake1[i][XLEN]) begin
            entries_d[i].rs1_ready      = 1'b1;
            entries_d[i].inst.rs1_value = wake1[i][XLEN-1:0];
         end
         if (entries_q[i].valid && !entries_q[i].rs2_ready && wake2[i][XLEN]) begin
            entries_d[i].rs2_ready      = 1'b1;
            entries_d[i].inst.rs2_value = wake2[i][XLEN-1:0];
         end
      end
      if (issue_fire) entries_d[sel_idx].valid = 1'b0;
      if (alloc_fire) entries_d[free_idx] = new_entry;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
      end
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(entries_d[i].valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         count_q   <= count_d;
      end
   end

   assign rs_count = count_q;

endmodule

// File: tb/tb_reservation_station_mc.sv
// Bench for reservation_station_mc: directed scenarios plus random traffic,
// checked every cycle against an allocation-sequence-number model.
module tb_reservation_station_mc;
   import reservation_station_mc_pkg::*;

   localparam int DEPTH = 8;
   localparam int NCDB  = 2;
   localparam int W     = 3 + 5 + 32 + 32;

   logic             clk = 1'b0;
   logic             reset, flush, alloc_enable, issue_stall;
   CDB_DATA          cdb [NCDB];
   ID_EX_PACKET      id_pkt;
   MAPTABLE_PACKET   mt1, mt2;
   logic [4:0]       alloc_slot;
   logic             rs_full, issue_valid;
   logic [3:0]       rs_count;
   INSTR_READY_ENTRY rie;

   always #5 clk = ~clk;

   reservation_station_mc #(.DEPTH(DEPTH), .NUM_CDB(NCDB), .NO_WAIT_RS2(1'b0)) dut (
      .clk                 (clk),
      .reset               (reset),
      .flush               (flush),
      .cdb                 (cdb),
      .id_packet_out       (id_pkt),
      .maptable_packet_rs1 (mt1),
      .maptable_packet_rs2 (mt2),
      .alloc_slot          (alloc_slot),
      .alloc_enable        (alloc_enable),
      .issue_stall         (issue_stall),
      .rs_full             (rs_full),
      .rs_count            (rs_count),
      .issue_valid         (issue_valid),
      .ready_inst_entry    (rie)
   );

   bit          m_valid [DEPTH];
   bit          m_r1 [DEPTH];
   bit          m_r2 [DEPTH];
   logic [4:0]  m_t1 [DEPTH];
   logic [4:0]  m_t2 [DEPTH];
   logic [4:0]  m_dest [DEPTH];
   logic [31:0] m_v1 [DEPTH];
   logic [31:0] m_v2 [DEPTH];
   longint      m_seq [DEPTH];
   longint      seq_ctr = 0;
   logic [W-1:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic bit cdb_find(input logic [4:0] tag, output logic [31:0] val);
      val = '0;
      for (int k = 0; k < NCDB; k++) begin
         if (cdb[k].valid && cdb[k].rob_tag == tag) begin
            val = cdb[k].value;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic model_capture(input MAPTABLE_PACKET mt, input logic [31:0] rf,
                                output bit rdy, output logic [4:0] tag, output logic [31:0] val);
      logic [31:0] v;
      tag = mt.rob_tag_val;
      val = rf;
      rdy = 1'b1;
      if (mt.rob_tag_val != 5'd0 && !mt.rob_tag_ready) begin
         rdy = cdb_find(mt.rob_tag_val, v);
         val = v;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
   endtask

   task automatic idle();
      reset = 1'b0; flush = 1'b0; alloc_enable = 1'b0; issue_stall = 1'b0;
      alloc_slot = '0; id_pkt = '0; mt1 = '0; mt2 = '0;
      for (int k = 0; k < NCDB; k++) cdb[k] = '0;
   endtask

   task automatic set_alloc(input logic [4:0] t1, input bit rdy1, input logic [31:0] v1,
                            input logic [4:0] t2, input bit rdy2, input logic [31:0] v2,
                            input logic [4:0] dest);
      alloc_enable     = 1'b1;
      mt1              = '{rob_tag_val: t1, rob_tag_ready: rdy1};
      mt2              = '{rob_tag_val: t2, rob_tag_ready: rdy2};
      id_pkt.pc        = $urandom;
      id_pkt.inst      = $urandom;
      id_pkt.rs1_value = v1;
      id_pkt.rs2_value = v2;
      alloc_slot       = dest;
   endtask

   task automatic set_cdb(input int k, input logic [4:0] tag, input logic [31:0] val);
      cdb[k] = '{valid: 1'b1, rob_tag: tag, value: val};
   endtask

   // One clock: compare outputs with the model, advance the model, cross the edge.
   task automatic step();
      int sel, cnt, free;
      bit full, exp_iv, fire, hit;
      logic [31:0] v;
      logic [W-1:0] exp_rec, got_rec;
      #1;
      cnt = 0; full = 1'b1; sel = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i]) cnt++; else full = 1'b0;
         if (m_valid[i] && m_r1[i] && m_r2[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
      end
      exp_iv = (sel >= 0) && !flush;
      n_checks++;
      if (rs_count !== 4'(cnt)) begin n_fail++; $display("FAIL model_rs_count got %0d exp %0d", rs_count, cnt); end
      n_checks++;
      if (rs_full !== full) begin n_fail++; $display("FAIL model_rs_full got %0b exp %0b", rs_full, full); end
      n_checks++;
      if (issue_valid !== exp_iv) begin n_fail++; $display("FAIL model_issue_valid got %0b exp %0b", issue_valid, exp_iv); end
      if (exp_iv) exp_q.push_back({3'(sel), m_dest[sel], m_v1[sel], m_v2[sel]});
      if (exp_iv && exp_q.size() > 0) begin
         exp_rec = exp_q.pop_front();
         got_rec = {rie.rs_idx, rie.rob_tag, rie.inst.rs1_value, rie.inst.rs2_value};
         n_checks++;
         if (got_rec !== exp_rec) begin
            n_fail++; $display("FAIL model_issue_entry got %h exp %h", got_rec, exp_rec);
         end
      end
      fire = exp_iv && !issue_stall;
      if (reset || flush) begin
         model_clear();
      end else begin
         free = -1;
         for (int i = DEPTH-1; i >= 0; i--) if (!m_valid[i]) free = i;
         for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && !m_r1[i]) begin hit = cdb_find(m_t1[i], v); if (hit) begin m_r1[i] = 1'b1; m_v1[i] = v; end end
            if (m_valid[i] && !m_r2[i]) begin hit = cdb_find(m_t2[i], v); if (hit) begin m_r2[i] = 1'b1; m_v2[i] = v; end end
         end
         if (fire) m_valid[sel] = 1'b0;
         if (alloc_enable && free >= 0) begin
            m_valid[free] = 1'b1;
            m_dest[free]  = alloc_slot;
            m_seq[free]   = seq_ctr++;
            model_capture(mt1, id_pkt.rs1_value, m_r1[free], m_t1[free], m_v1[free]);
            model_capture(mt2, id_pkt.rs2_value, m_r2[free], m_t2[free], m_v2[free]);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      #1;
      n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", rs_count); end
      n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", rs_full); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got %0b exp 0", issue_valid); end
   endtask

   task automatic test_in_order_issue();
      for (int i = 0; i < 3; i++) begin
         idle(); issue_stall = 1'b1;
         set_alloc(5'd0, 1'b0, 32'(100 + i), 5'd0, 1'b0, 32'(200 + i), 5'(i + 1));
         step();
      end
      for (int i = 0; i < 3; i++) begin
         idle(); #1;
         n_checks++; if (rs_count !== 4'(3 - i)) begin n_fail++; $display("FAIL order_count got %0d exp %0d", rs_count, 3 - i); end
         n_checks++; if (issue_valid !== 1'b1 || rie.rs_idx !== 3'(i)) begin n_fail++; $display("FAIL order_idx got %0d/%0b exp %0d/1", rie.rs_idx, issue_valid, i); end
         step();
      end
      #1;
      n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL order_drain got %0d exp 0", rs_count); end
   endtask

   task automatic test_dual_wakeup();
      idle(); set_alloc(5'd5, 1'b0, 32'h0, 5'd6, 1'b0, 32'h0, 5'd9); step();
      idle(); set_cdb(0, 5'd5, 32'hAA); set_cdb(1, 5'd6, 32'hBB); #1;
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL dual_wait got %0b exp 0", issue_valid); end
      step();
      idle(); #1;
      n_checks++;
      if (issue_valid !== 1'b1 || rie.inst.rs1_value !== 32'hAA || rie.inst.rs2_value !== 32'hBB || rie.rob_tag !== 5'd9) begin
         n_fail++; $display("FAIL dual_wake got %0b %h %h %0d exp 1 aa bb 9", issue_valid, rie.inst.rs1_value, rie.inst.rs2_value, rie.rob_tag);
      end
      step();
   endtask

   task automatic test_alloc_capture();
      idle(); set_alloc(5'd7, 1'b0, 32'hDEAD, 5'd0, 1'b0, 32'h55, 5'd10); set_cdb(1, 5'd7, 32'h1234); step();
      idle(); #1;
      n_checks++;
      if (issue_valid !== 1'b1 || rie.inst.rs1_value !== 32'h1234 || rie.inst.rs2_value !== 32'h55) begin
         n_fail++; $display("FAIL alloc_capture got %0b %h %h exp 1 1234 55", issue_valid, rie.inst.rs1_value, rie.inst.rs2_value);
      end
      step(); #1;
      n_checks++; if (rs_count !== 4'd0) begin n_fail++; $display("FAIL capture_drain got %0d exp 0", rs_count); end
   endtask

   task automatic test_full_stall();
      for (int i = 0; i < DEPTH; i++) begin
         idle(); set_alloc(5'(16 + i), 1'b0, 32'h0, 5'd0, 1'b0, 32'(i), 5'(i)); step();
      end
      idle(); set_alloc(5'd0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd31); #1;
      n_checks++; if (rs_full !== 1'b1 || rs_count !== 4'd8) begin n_fail++; $display("FAIL full_flag got %0b/%0d exp 1/8", rs_full, rs_count); end
      step(); #1;
      n_checks++; if (rs_count !== 4'd8) begin n_fail++; $display("FAIL full_ignore got %0d exp 8", rs_count); end
      idle(); issue_stall = 1'b1; set_cdb(0, 5'd19, 32'h33); step();
      for (int c = 0; c < 2; c++) begin
         idle(); issue_stall = 1'b1; #1;
         n_checks++;
         if (issue_valid !== 1'b1 || rie.rs_idx !== 3'd3 || rs_count !== 4'd8) begin
            n_fail++; $display("FAIL stall_hold got %0b/%0d/%0d exp 1/3/8", issue_valid, rie.rs_idx, rs_count);
         end
         step();
      end
      idle(); step(); #1;
      n_checks++; if (rs_count !== 4'd7 || rs_full !== 1'b0) begin n_fail++; $display("FAIL stall_release got %0d/%0b exp 7/0", rs_count, rs_full); end
      idle(); flush = 1'b1; step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 80; c++) begin
         idle();
         issue_stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0)
            set_alloc(5'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), $urandom,
                      5'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), $urandom,
                      5'($urandom_range(0, 31)));
         for (int k = 0; k < NCDB; k++)
            if ($urandom_range(0, 1) == 1) set_cdb(k, 5'($urandom_range(1, 12)), $urandom);
         if ($urandom_range(0, 39) == 0) flush = 1'b1;
         step();
      end
      idle(); flush = 1'b1; step();
   endtask

   task automatic test_age_order();
      for (int i = 0; i < 6; i++) begin
         idle(); set_alloc(5'(16 + i), 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'(i)); step();
      end
      idle(); set_cdb(0, 5'd16, 32'h10); step();
      idle(); step();
      idle(); set_alloc(5'd30, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd20); step();
      idle(); set_cdb(0, 5'd30, 32'h300); set_cdb(1, 5'd21, 32'h210); step();
      idle(); #1;
      n_checks++; if (issue_valid !== 1'b1 || rie.rs_idx !== 3'd5) begin n_fail++; $display("FAIL age_first got %0b/%0d exp 1/5", issue_valid, rie.rs_idx); end
      step();
      idle(); #1;
      n_checks++; if (issue_valid !== 1'b1 || rie.rs_idx !== 3'd0 || rie.rob_tag !== 5'd20) begin n_fail++; $display("FAIL age_second got %0b/%0d exp 1/0", issue_valid, rie.rs_idx); end
      step();
      idle(); flush = 1'b1; step();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) begin
         idle(); issue_stall = 1'b1;
         set_alloc(i == 3 ? 5'd12 : 5'd0, 1'b0, 32'(i), 5'd0, 1'b0, 32'h0, 5'(i)); step();
      end
      idle(); flush = 1'b1; set_alloc(5'd0, 1'b0, 32'h9, 5'd0, 1'b0, 32'h9, 5'd7); set_cdb(0, 5'd12, 32'hC); #1;
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_issue got %0b exp 0", issue_valid); end
      step();
      idle(); #1;
      n_checks++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after got %0d/%0b exp 0/0", rs_count, issue_valid); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         idle(); issue_stall = 1'b1; set_alloc(5'd0, 1'b0, 32'h1, 5'd0, 1'b0, 32'h2, 5'(i)); step();
      end
      idle(); reset = 1'b1; step();
      idle(); #1;
      n_checks++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid got %0d/%0b exp 0/0", rs_count, issue_valid); end
      for (int i = 0; i < 2; i++) begin
         idle(); issue_stall = 1'b1; set_alloc(5'd0, 1'b0, 32'(i), 5'd0, 1'b0, 32'h0, 5'(i + 3)); step();
      end
      idle(); step();
      idle(); step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_in_order_issue();
      test_dual_wakeup();
      test_alloc_capture();
      test_full_stall();
      test_random();
      test_age_order();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reservation_station_mc.md
Name: reservation_station_mc

Overview:
Parametrised next-generation reservation station that sits between decode/rename and one execution unit. It accepts one instruction per cycle and snoops NUM_CDB result buses, so both operands can wake in the same cycle, and it captures results broadcast in the allocation cycle. It picks the oldest ready entry using a wrap-free age matrix rather than a saturating birthday counter, and it supports a whole-station flush on mispredict.

Parameters:
DEPTH, 8, number of entries (power of 2 not required, >=2)
NUM_CDB, 2, number of CDB broadcast ports snooped per cycle
NO_WAIT_RS2, 0, 1 = entry is ready on rs1 alone (stores, immediates)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  squash all entries (mispredict recovery)
cdb  input  CDB_DATA[NUM_CDB]  result broadcasts (valid, rob_tag, value)
id_packet_out  input  ID_EX_PACKET  decoded instruction with regfile rs1/rs2 values
maptable_packet_rs1  input  MAPTABLE_PACKET  rs1 rename lookup (rob_tag_val, rob_tag_ready)
maptable_packet_rs2  input  MAPTABLE_PACKET  rs2 rename lookup
alloc_slot  input  `ROB_TAG_LEN  destination ROB tag
alloc_enable  input  1  allocate request
issue_stall  input  1  execution unit cannot accept this cycle
rs_full  output  1  no free entry
rs_count  output  $clog2(DEPTH+1)  valid entries
issue_valid  output  1  ready_inst_entry holds a ready instruction
ready_inst_entry  output  INSTR_READY_ENTRY  oldest ready entry

Behaviour:
- One clock (clk); reset synchronous active-high. Reset: all entries invalid, age matrix cleared, rs_full=0, rs_count=0, issue_valid=0. Entry payload fields are don't-care.
- Entry ready = valid & rs1_ready & (rs2_ready | NO_WAIT_RS2).
- Issue (combinational from registered state, 0-cycle latency): issue_valid=1 when any entry is ready. Select the ready entry i with no other ready entry older than i. When issue_valid=0, ready_inst_entry is don't-care.
- Handshake: if issue_valid & !issue_stall at posedge, the selected entry goes invalid. Under a stall the entry and selection hold, unless an older entry becomes ready, in which case the selection changes.
- Allocation: accepted when alloc_enable & !rs_full. Free slot = lowest-index invalid entry. rs_full is computed from current state only; an issue-free in the same cycle does not admit an allocation into a full station.
- Operand capture at allocation, per operand, with the first matching rule taking effect:
  (a) tag==0 -> ready, regfile value.
  (b) maptable ready -> ready, regfile value.
  (c) any valid cdb[k].rob_tag==tag in the same cycle -> ready, cdb value (lowest k wins).
  (d) otherwise -> not ready, waits on the tag.
- Wakeup: every valid entry's operand that is not yet ready compares against all NUM_CDB ports each cycle.
  - rs1 and rs2 wake independently and may wake in the same cycle, from the same or different ports.
  - An operand that is already ready is never overwritten.
  - If several ports match one operand, the lowest index wins.
- Age matrix: age[i][j]=1 means i is older than j. On allocation into slot n: age[n][*]=0, and age[j][n]=1 for every j that is valid after this edge's issue-free (an entry allocated and issued in the same cycle does not count). Freeing an entry needs no matrix update, because invalid rows and columns are masked.
- rs_count = popcount(valid), registered. It moves by +1, -1 or 0 (0 when an allocation and an issue happen together).
- flush: at the next edge all entries are invalid and rs_count=0. Flush overrides same-cycle allocation and wakeup. issue_valid is forced to 0 during the flush cycle, so no issue is consumed.
- reset mid-operation: same as flush, plus the age matrix is cleared.
- The aging scheme has no counter and therefore no wrap-around. Ordering stays correct across an unbounded number of allocations.

Decomposition:
- Shared package: RS_IDX_LEN = $clog2(DEPTH), NUM_CDB default, and INSTR_READY_ENTRY. The package must not carry birthday fields; the age matrix replaces them.
- Sub-module rs_age_matrix (DEPTH): inputs alloc_en, alloc_idx, valid_mask, ready_mask; outputs oldest_onehot and any_ready.

Test Plan:
1. Reset, then three allocations with rs tags 0 -> entries 0,1,2 ready; issue order entry0, entry1, entry2 on consecutive cycles; rs_count goes 3,2,1,0.
2. Allocate an entry waiting on rs1 tag 5 and rs2 tag 6; drive cdb[0]=(tag5,0xAA) and cdb[1]=(tag6,0xBB) in the same cycle -> next cycle issue_valid=1 with rs1_value=0xAA and rs2_value=0xBB.
3. Allocate with rs1 tag 7 not ready while cdb[1]=(tag7,0x1234) in the same cycle -> entry captured ready with 0x1234; issued the next cycle.
4. Fill all 8 entries with unready operands -> rs_full=1; alloc_enable is ignored (rs_count stays 8). Wake entry 3 and hold issue_stall for 2 cycles -> entry 3 persists; releasing the stall frees it and rs_full=0.
5. Run 20 allocate/issue cycles with slot reuse, then make a younger entry in slot 0 and an older one in slot 5 ready together -> slot 5 issues first.
6. With 4 entries valid, assert flush together with alloc_enable and a matching CDB -> next cycle rs_count=0 and issue_valid=0; the flush cycle shows issue_valid=0.
